// File: rtl/bitserial_mac_pkg.sv
// bitserial_mac_pkg: shared state encoding and width defaults for the bit-serial MAC controller
package bitserial_mac_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, WAIT, OUT} state_t;
   localparam int DATA_W_DEF = 16;
   localparam int ACC_W_DEF = 40;
   localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/bitserial_piso.sv
// bitserial_piso: LSB-first parallel-in/serial-out register, zero-filled as it shifts
module bitserial_piso
   import bitserial_mac_pkg::*;
#(
   parameter int W = DATA_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         bit_out
);
   logic [W-1:0] sr;
   always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else if (load) sr <= din;
      else if (shift) sr <= sr >> 1;
   end
   assign bit_out = sr[0];
endmodule

// File: rtl/bitserial_mac_ctrl.sv
// bitserial_mac_ctrl: streams operand pairs through a bit-serial multiplier and accumulates a dot product
module bitserial_mac_ctrl
   import bitserial_mac_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int WAIT_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_ovf,
   output logic              err_timeout,
   output logic              mult_start,
   output logic [DATA_W-1:0] mult_multiplicand,
   output logic [DATA_W-1:0] mult_multiplier,
   output logic              mult_serial_bit,
   input  logic              mult_done,
   input  logic [2*DATA_W-1:0] mult_product
);
   localparam int K_W = $clog2(DATA_W);
   localparam int W_W = $clog2(WAIT_MAX + 1);
   state_t state;
   logic [K_W-1:0] k;
   logic [W_W-1:0] wcnt;
   logic last;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic ovf;
   logic load;
   logic [ACC_W:0] sum;
   assign in_ready = state == IDLE;
   assign load = in_valid && in_ready;
   assign sum = {1'b0, acc} + (ACC_W + 1)'(mult_product);
   assign out_acc = acc;
   assign out_cnt = cnt;
   assign out_ovf = ovf;
   bitserial_piso #(.W(DATA_W)) u_piso (
      .clk(clk),
      .rst(rst),
      .load(load),
      .shift(state == SHIFT),
      .din(in_b),
      .bit_out(mult_serial_bit)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         k <= '0;
         wcnt <= '0;
         last <= 1'b0;
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
         err_timeout <= 1'b0;
         mult_start <= 1'b0;
         out_valid <= 1'b0;
         mult_multiplicand <= '0;
         mult_multiplier <= '0;
      end else begin
         mult_start <= load;
         case (state)
            IDLE: if (load) begin
               mult_multiplicand <= in_a;
               mult_multiplier <= in_b;
               last <= in_last;
               k <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               k <= k + 1'b1;
               if (k == K_W'(DATA_W - 1)) begin
                  wcnt <= '0;
                  state <= WAIT;
               end
            end
            WAIT: if (mult_done) begin
               acc <= sum[ACC_W-1:0];
               cnt <= cnt + CNT_W'(~&cnt);
               ovf <= ovf | sum[ACC_W] | (&cnt);
               out_valid <= last;
               state <= last ? OUT : IDLE;
            end else if (wcnt == W_W'(WAIT_MAX - 1)) begin
               // a stalled multiplier poisons the whole vector, so drop it
               err_timeout <= 1'b1;
               acc <= '0;
               cnt <= '0;
               ovf <= 1'b0;
               state <= IDLE;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
            OUT: if (out_ready) begin
               out_valid <= 1'b0;
               acc <= '0;
               cnt <= '0;
               ovf <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bitserial_mac_ctrl.sv
// tb_bitserial_mac_ctrl: random and directed vectors against a dot-product reference and a serial multiplier model
module tb_bitserial_mac_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic in_last = 1'b0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [39:0] out_acc;
   logic [7:0] out_cnt;
   logic out_ovf;
   logic err_timeout;
   logic mult_start;
   logic [15:0] mult_multiplicand;
   logic [15:0] mult_multiplier;
   logic mult_serial_bit;
   logic mult_done;
   logic [31:0] mult_product;
   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int accept_cyc = 0;
   logic [63:0] ref_sum = '0;
   int ref_n = 0;
   logic done_en = 1'b1;
   logic [15:0] m_bits;
   int m_cnt;
   logic m_busy, m_done;
   logic [31:0] m_prod;

   bitserial_mac_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_cnt(out_cnt), .out_ovf(out_ovf), .err_timeout(err_timeout),
      .mult_start(mult_start), .mult_multiplicand(mult_multiplicand),
      .mult_multiplier(mult_multiplier), .mult_serial_bit(mult_serial_bit),
      .mult_done(mult_done), .mult_product(mult_product)
   );

   always #5 clk = ~clk;

   // multiplier model rebuilds b from the serial stream; done appears 18 cycles after start
   assign mult_done = m_done & done_en;
   assign mult_product = m_prod;
   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_cnt <= 0;
         m_prod <= '0;
      end else if (mult_start) begin
         m_done <= 1'b0;
         m_busy <= 1'b1;
         m_cnt <= 1;
         m_bits <= {15'b0, mult_serial_bit};
      end else if (m_busy) begin
         if (m_cnt < 16) m_bits[m_cnt] <= mult_serial_bit;
         m_cnt <= m_cnt + 1;
         if (m_cnt == 17) begin
            m_done <= 1'b1;
            m_busy <= 1'b0;
            m_prod <= 32'(mult_multiplicand) * 32'(m_bits);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!in_ready && t < 100) begin
         step();
         t++;
      end
      if (!in_ready) check("ready_timeout", 0, 1);
   endtask

   task automatic send_elem(input logic [15:0] a, input logic [15:0] b, input logic last);
      in_a = a;
      in_b = b;
      in_last = last;
      in_valid = 1'b1;
      wait_ready();
      accept_cyc = cyc;
      step();
      in_valid = 1'b0;
      ref_sum += 64'(a) * 64'(b);
      ref_n++;
      for (int i = 0; i < 16; i++) begin
         check("start", mult_start, i == 0);
         check("sbit", mult_serial_bit, b[i]);
         check("mcand", mult_multiplicand, a);
         check("mplier", mult_multiplier, b);
         step();
      end
   endtask

   task automatic finish_vec(input int dly);
      int t = 0;
      logic [63:0] e_acc;
      e_acc = 64'(ref_sum[39:0]);
      while (!out_valid && t < 100) begin
         step();
         t++;
      end
      check("out_valid", out_valid, 1);
      check("out_acc", out_acc, e_acc);
      check("out_cnt", out_cnt, ref_n > 255 ? 255 : ref_n);
      check("out_ovf", out_ovf, (ref_sum >> 40) != 0 || ref_n > 255);
      for (int i = 0; i < dly; i++) begin
         step();
         check("hold_valid", out_valid, 1);
         check("hold_acc", out_acc, e_acc);
         check("hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("drain_valid", out_valid, 0);
      check("drain_ready", in_ready, 1);
      ref_sum = '0;
      ref_n = 0;
   endtask

   initial begin
      int n;
      step();
      step();
      rst = 1'b0;
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_err", err_timeout, 0);
      check("rst_start", mult_start, 0);
      check("rst_sbit", mult_serial_bit, 0);
      check("rst_acc", out_acc, 0);
      check("rst_cnt", out_cnt, 0);
      check("rst_mcand", mult_multiplicand, 0);
      // single element and its latency
      send_elem(16'd3, 16'd5, 1'b1);
      while (!out_valid && cyc - accept_cyc < 40) step();
      check("latency", cyc - accept_cyc, 20);
      finish_vec(0);
      // three-element vector, non-last element returns to IDLE at cycle 20
      send_elem(16'd2, 16'd7, 1'b0);
      wait_ready();
      check("elem_latency", cyc - accept_cyc, 20);
      send_elem(16'd10, 16'd10, 1'b0);
      send_elem(16'hFFFF, 16'hFFFF, 1'b1);
      check("spec_sum", ref_sum, 64'd4294836339);
      finish_vec(0);
      // serial pattern, then back-pressure on the result
      send_elem(16'd1, 16'hA5A5, 1'b1);
      finish_vec(10);
      // timeout discards a partially built vector
      send_elem(16'd100, 16'd100, 1'b0);
      wait_ready();
      done_en = 1'b0;
      send_elem(16'd9, 16'd9, 1'b1);
      repeat (7) step();
      check("err_early", err_timeout, 0);
      step();
      check("err_set", err_timeout, 1);
      check("err_idle", in_ready, 1);
      ref_sum = '0;
      ref_n = 0;
      done_en = 1'b1;
      send_elem(16'd4, 16'd5, 1'b1);
      finish_vec(0);
      check("err_sticky", err_timeout, 1);
      // reset in the middle of SHIFT
      in_a = 16'd7;
      in_b = 16'hFFFF;
      in_last = 1'b1;
      in_valid = 1'b1;
      wait_ready();
      step();
      in_valid = 1'b0;
      repeat (7) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_ready", in_ready, 1);
      check("abort_start", mult_start, 0);
      check("abort_sbit", mult_serial_bit, 0);
      check("abort_valid", out_valid, 0);
      check("abort_err", err_timeout, 0);
      check("abort_acc", out_acc, 0);
      check("abort_cnt", out_cnt, 0);
      check("abort_mcand", mult_multiplicand, 0);
      check("abort_mplier", mult_multiplier, 0);
      step();
      check("abort_ready2", in_ready, 1);
      send_elem(16'd4, 16'd4, 1'b1);
      finish_vec(0);
      // random vectors; stray out_ready during accumulation must be ignored
      for (int v = 0; v < 6; v++) begin
         n = $urandom_range(1, 4);
         out_ready = 1'($urandom_range(0, 1));
         for (int e = 0; e < n; e++) begin
            repeat ($urandom_range(0, 3)) step();
            if (e == n - 1) out_ready = 1'b0;
            send_elem(16'($urandom), 16'($urandom), e == n - 1);
         end
         finish_vec($urandom_range(0, 3));
      end
      // long near-full-scale vector wraps the accumulator and saturates the count
      for (int e = 0; e < 300; e++)
         send_elem(16'hFFFF - 16'($urandom_range(0, 3)), 16'hFFFF - 16'($urandom_range(0, 3)), e == 299);
      finish_vec(1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
